// File: rtl/fetch_responder.sv
// Instruction-fetch responder: holds PC and IR, drives a wait-stated memory read
// port on behalf of the multi-cycle control FSM and reports fetch completion/errors.
module fetch_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req_i,
  input  logic               pc_write_i,
  input  logic [ADDR_W-1:0]  pc_target_i,
  output logic               mem_rd_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] ir_o,
  output logic [3:0]         op_type_o,
  output logic               reg_imm_o,
  output logic               instr_valid_o,
  output logic               busy_o,
  output logic               fetch_err_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [ADDR_W-1:0]    ptgt_q, ptgt_d;
  logic                 mem_rd_q, valid_q, busy_q, err_q;
  logic                 redirect;
  logic [ADDR_W-1:0]    redirect_pc;

  // A branch arriving in the same cycle as the ack still wins over pc+1.
  assign redirect    = pend_q | pc_write_i;
  assign redirect_pc = pc_write_i ? pc_target_i : ptgt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RST;
      ir_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      ptgt_q   <= '0;
      mem_rd_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ptgt_q   <= ptgt_d;
      mem_rd_q <= (state_d == S_REQ);
      valid_q  <= (state_d == S_DONE);
      busy_q   <= (state_d == S_REQ) || (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        // A direct PC load supersedes any branch left pending by a failed fetch.
        if (pc_write_i) begin
          pc_d   = pc_target_i;
          pend_d = 1'b0;
        end
        if (fetch_req_i) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (pc_write_i) begin
          pend_d = 1'b1;
          ptgt_d = pc_target_i;
        end
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = redirect ? redirect_pc : pc_q + ADDR_W'(1);
          pend_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (pc_write_i) begin
          pc_d   = pc_target_i;
          pend_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign ir_o          = ir_q;
  assign op_type_o     = ir_q[INSTR_W-1 -: 4];
  assign reg_imm_o     = ir_q[INSTR_W-5];
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed scenarios then randomized traffic, all
// checked against a transaction-level reference model of the fetch rules.
module tb_fetch_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, pc_write, mem_ack;
  logic [7:0]  pc_target;
  logic [15:0] mem_rdata;
  logic        mem_rd, instr_valid, busy, fetch_err, reg_imm;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;
  logic [3:0]  op_type;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 waiting on memory, 2 completing, 3 failed.
  int          m_phase;
  int          m_waited;
  int          m_pc;
  int          m_ir;
  bit          m_has_branch;
  int          m_branch;

  fetch_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req_i   (fetch_req),
    .pc_write_i    (pc_write),
    .pc_target_i   (pc_target),
    .mem_rd_o      (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .mem_ack_i     (mem_ack),
    .pc_o          (pc),
    .ir_o          (ir),
    .op_type_o     (op_type),
    .reg_imm_o     (reg_imm),
    .instr_valid_o (instr_valid),
    .busy_o        (busy),
    .fetch_err_o   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_pc = 0; m_ir = 0; m_has_branch = 0; m_branch = 0;
  endtask

  // Apply one clock of the fetch rules to the model using the driven inputs.
  task automatic model_step();
    case (m_phase)
      0, 3: begin
        if (pc_write) begin m_pc = pc_target; m_has_branch = 0; end
        if (fetch_req) begin m_phase = 1; m_waited = 0; end
      end
      1: begin
        if (pc_write) begin m_has_branch = 1; m_branch = pc_target; end
        if (mem_ack) begin
          m_ir = mem_rdata;
          m_pc = m_has_branch ? m_branch : (m_pc + 1) % 256;
          m_has_branch = 0;
          m_phase = 2;
        end else begin
          m_waited++;
          if (m_waited >= 15) m_phase = 3;
        end
      end
      default: begin
        if (pc_write) begin m_pc = pc_target; m_has_branch = 0; end
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("pc",       32'(pc),       32'(m_pc));
    check_eq("mem_addr", 32'(mem_addr), 32'(m_pc));
    check_eq("ir",       32'(ir),       32'(m_ir));
    check_eq("fields",   {27'd0, op_type, reg_imm}, 32'(((m_ir / 4096) * 2) + ((m_ir / 2048) % 2)));
    check_eq("ctrl",     {28'd0, mem_rd, instr_valid, busy, fetch_err},
             {28'd0, m_phase == 1, m_phase == 2, m_phase == 1 || m_phase == 2, m_phase == 3});
  endtask

  // Called on a falling edge: check, drive, clock, advance model, return on next fall.
  task automatic cycle(input logic fr, input logic pw, input logic [7:0] tgt,
                       input logic ack, input logic [15:0] rd);
    check_outputs();
    fetch_req = fr; pc_write = pw; pc_target = tgt; mem_ack = ack; mem_rdata = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic random_run(input int n, input int ack_pct, input int fr_pct, input int pw_pct);
    for (int i = 0; i < n; i++)
      cycle(($urandom % 100) < fr_pct, ($urandom % 100) < pw_pct, 8'($urandom),
            ($urandom % 100) < ack_pct, 16'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 0; pc_write = 0; pc_target = 0; mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait fetch of 9A55.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    check_eq("zw_mem_rd", 32'(mem_rd), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h9A55);
    check_eq("zw_valid", 32'(instr_valid), 32'd1);
    check_eq("zw_ir", 32'(ir), 32'h9A55);
    check_eq("zw_op", 32'(op_type), 32'd9);
    check_eq("zw_imm", 32'(reg_imm), 32'd1);
    check_eq("zw_pc", 32'(pc), 32'd1);
    idle(1);

    // Three wait states.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    idle(3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234);
    check_eq("ws_pc", 32'(pc), 32'd2);
    idle(1);

    // Branch while waiting, ack two cycles later.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 8'h40, 1'b0, 16'h0000);
    idle(1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h5A5A);
    check_eq("br_pc", 32'(pc), 32'h40);
    idle(1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    check_eq("br_addr", 32'(mem_addr), 32'h40);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h0F0F);
    idle(1);

    // Wrap from FF to 00.
    cycle(1'b1, 1'b1, 8'hFF, 1'b0, 16'h0000);
    check_eq("wr_addr", 32'(mem_addr), 32'hFF);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'hC3C3);
    check_eq("wr_pc", 32'(pc), 32'h00);
    idle(1);

    // Timeout then retry.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    idle(15);
    check_eq("to_err", 32'(fetch_err), 32'd1);
    check_eq("to_pc", 32'(pc), 32'd0);
    check_eq("to_ir", 32'(ir), 32'hC3C3);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    check_eq("rt_err", 32'(fetch_err), 32'd0);
    check_eq("rt_addr", 32'(mem_addr), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'h7777);
    idle(1);

    // Asynchronous reset in the middle of a fetch.
    cycle(1'b1, 1'b1, 8'h33, 1'b0, 16'h0000);
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("ar_busy", 32'(busy), 32'd0);
    check_eq("ar_pc", 32'(pc), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 16'hDEAD);
    check_eq("late_ack_ir", 32'(ir), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 16'h2468);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    idle(2);

    // Randomized traffic under different memory behaviours.
    random_run(800, 50, 40, 15);
    random_run(300, 0, 30, 10);
    random_run(600, 100, 50, 20);
    random_run(800, 20, 60, 30);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
